// File: rtl/data_mem_responder_pkg.sv
// Shared types and defaults for the data-memory responder: funct3 codes,
// FSM state encoding and default geometry/timing.
package data_mem_responder_pkg;

   localparam int DEFAULT_DEPTH_WORDS = 256;
   localparam int DEFAULT_WAIT_STATES = 1;

   // Load and store codes share values, so they live in two enums.
   typedef enum logic [2:0] {
      F3_LB  = 3'b000,
      F3_LH  = 3'b001,
      F3_LW  = 3'b010,
      F3_LBU = 3'b100,
      F3_LHU = 3'b101
   } load_funct3_e;

   typedef enum logic [2:0] {
      F3_SB = 3'b000,
      F3_SH = 3'b001,
      F3_SW = 3'b010
   } store_funct3_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

endpackage

// File: rtl/data_mem_responder_if.sv
// Core-side request/response bus of the data-memory responder.
interface data_mem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [2:0]  req_funct3;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/data_mem_responder_load_store_align.sv
// Byte-lane steering: store data replication plus byte enables, and load
// byte/halfword extraction with sign or zero extension.
module load_store_align
   import data_mem_responder_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rword_i,
   output logic [31:0] wdata_o,
   output logic [3:0]  be_o,
   output logic [31:0] ldata_o
);
   logic [7:0]  lane [4];
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = rword_i[gi*8 +: 8];
   end

   assign byte_sel = lane[addr_lo_i];
   assign half_sel = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];

   // Data is replicated across lanes so the enables alone pick the target bytes.
   always_comb begin
      wdata_o = wdata_i;
      be_o    = 4'b0000;
      case (funct3_i[1:0])
         2'b00: begin
            wdata_o = {4{wdata_i[7:0]}};
            be_o    = 4'b0001 << addr_lo_i;
         end
         2'b01: begin
            wdata_o = {2{wdata_i[15:0]}};
            be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
         end
         2'b10:   be_o = 4'b1111;
         default: be_o = 4'b0000;
      endcase
   end

   always_comb begin
      ldata_o = '0;
      case (funct3_i)
         F3_LB:   ldata_o = {{24{byte_sel[7]}}, byte_sel};
         F3_LH:   ldata_o = {{16{half_sel[15]}}, half_sel};
         F3_LW:   ldata_o = rword_i;
         F3_LBU:  ldata_o = {24'd0, byte_sel};
         F3_LHU:  ldata_o = {16'd0, half_sel};
         default: ldata_o = '0;
      endcase
   end
endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder backed by an inferred word memory
// with byte-lane writes and a programmable number of wait states.
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
   parameter int WAIT_STATES = DEFAULT_WAIT_STATES
) (
   input  logic              clk,
   input  logic              rst,
   data_mem_responder_if.slave bus
);
   localparam int         IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);
   localparam logic [1:0] IDLE      = ST_IDLE;
   localparam logic [1:0] WAIT      = ST_WAIT;
   localparam logic [1:0] RESP      = ST_RESP;

   logic [1:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q;
   logic [31:0] addr_q, wdata_q;
   logic [2:0]  funct3_q;
   logic [31:0] rword_q;
   logic [31:0] mem [DEPTH_WORDS];

   logic        is_idle, accept, enter_resp;
   logic        cur_we;
   logic [31:0] cur_addr, cur_wdata;
   logic [2:0]  cur_f3;
   logic        misalign, out_of_range, bad_f3, err_c;
   logic [IDX_W-1:0] idx;
   logic [31:0] st_data, ld_data;
   logic [3:0]  st_be;

   assign is_idle = (state_q == IDLE);
   assign accept  = is_idle && bus.req_valid;

   // With zero wait states the access resolves on the accept edge, so the
   // live request is used in IDLE and the captured copy everywhere else.
   assign cur_we    = is_idle ? bus.req_we     : we_q;
   assign cur_addr  = is_idle ? bus.req_addr   : addr_q;
   assign cur_wdata = is_idle ? bus.req_wdata  : wdata_q;
   assign cur_f3    = is_idle ? bus.req_funct3 : funct3_q;

   assign misalign     = ((cur_f3[1:0] == 2'b01) && cur_addr[0]) ||
                         ((cur_f3[1:0] == 2'b10) && (cur_addr[1:0] != 2'b00));
   assign out_of_range = {2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS);
   assign bad_f3       = cur_we ? (cur_f3 > 3'b010)
                                : ((cur_f3 == 3'b011) || (cur_f3[2:1] == 2'b11));
   assign err_c        = misalign || out_of_range || bad_f3;
   assign idx          = cur_addr[IDX_W+1:2];

   load_store_align u_align (
      .funct3_i  (cur_f3),
      .addr_lo_i (cur_addr[1:0]),
      .wdata_i   (cur_wdata),
      .rword_i   (rword_q),
      .wdata_o   (st_data),
      .be_o      (st_be),
      .ldata_o   (ld_data)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: if (bus.req_valid) begin
            if (WAIT_STATES == 0) begin
               state_d = RESP;
            end else begin
               state_d = WAIT;
               cnt_d   = WAIT_LOAD;
            end
         end
         WAIT: if (cnt_q <= 4'd1) begin
            state_d = RESP;
            cnt_d   = 4'd0;
         end else begin
            cnt_d = cnt_q - 4'd1;
         end
         RESP:    if (bus.rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign enter_resp = (state_q != RESP) && (state_d == RESP);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         funct3_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            we_q     <= bus.req_we;
            addr_q   <= bus.req_addr;
            wdata_q  <= bus.req_wdata;
            funct3_q <= bus.req_funct3;
         end
      end
   end

   // Memory is deliberately outside reset; an asserted reset only blocks the access.
   always_ff @(posedge clk) begin
      if (rst && enter_resp) begin
         rword_q <= mem[idx];
         if (cur_we && !err_c) begin
            for (int i = 0; i < 4; i++) begin
               if (st_be[i]) mem[idx][i*8 +: 8] <= st_data[i*8 +: 8];
            end
         end
      end
   end

   assign bus.req_ready = is_idle;
   assign bus.rsp_valid = (state_q == RESP);
   assign bus.rsp_err   = bus.rsp_valid && err_c;
   assign bus.rsp_rdata = (bus.rsp_valid && !err_c && !we_q) ? ld_data : 32'd0;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: stores, loads, extension, errors,
// backpressure and reset-abort, each against hand-computed results.
module tb_data_mem_responder;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_total = 0;
   int   n_bad   = 0;

   always #5 clk = ~clk;

   data_mem_responder_if bus ();

   data_mem_responder #(
      .DEPTH_WORDS (256),
      .WAIT_STATES (1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h want=%h", tag, got, exp);
      end
   endtask

   task automatic txn(input string name, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [2:0] f3, input int hold,
                      input logic [31:0] exp_rdata, input logic exp_err);
      int lat;
      @(negedge clk);
      chk({name, ".req_ready_idle"}, 32'(bus.req_ready), 32'd1);
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      bus.req_funct3 = f3;
      @(negedge clk);
      bus.req_valid = 1'b0;
      lat = 1;
      while (!bus.rsp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk({name, ".latency"}, 32'(lat), 32'd2);
      chk({name, ".rdata"}, bus.rsp_rdata, exp_rdata);
      chk({name, ".err"}, 32'(bus.rsp_err), 32'(exp_err));
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk({name, ".hold_valid"}, 32'(bus.rsp_valid), 32'd1);
         chk({name, ".hold_rdata"}, bus.rsp_rdata, exp_rdata);
         chk({name, ".hold_req_ready"}, 32'(bus.req_ready), 32'd0);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      chk({name, ".valid_drop"}, 32'(bus.rsp_valid), 32'd0);
      chk({name, ".ready_back"}, 32'(bus.req_ready), 32'd1);
      $display("txn %-10s we=%0d addr=%h wdata=%h f3=%0d lat=%0d rdata=%h err=%0d",
               name, we, addr, wdata, f3, lat, exp_rdata, exp_err);
   endtask

   initial begin
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      bus.req_funct3 = '0;
      bus.rsp_ready  = 1'b0;

      repeat (3) @(negedge clk);
      chk("reset.rsp_valid", 32'(bus.rsp_valid), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("reset.req_ready", 32'(bus.req_ready), 32'd1);
      chk("reset.rsp_rdata", bus.rsp_rdata, 32'd0);
      chk("reset.rsp_err", 32'(bus.rsp_err), 32'd0);

      txn("sw_10",   1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 0, 32'h0,        1'b0);
      txn("lw_10",   1'b0, 32'h10, 32'h0,        3'b010, 0, 32'hDEADBEEF, 1'b0);
      txn("lb_13",   1'b0, 32'h13, 32'h0,        3'b000, 0, 32'hFFFFFFDE, 1'b0);
      txn("lbu_13",  1'b0, 32'h13, 32'h0,        3'b100, 0, 32'h000000DE, 1'b0);
      txn("lh_12",   1'b0, 32'h12, 32'h0,        3'b001, 0, 32'hFFFFDEAD, 1'b0);
      txn("lhu_10",  1'b0, 32'h10, 32'h0,        3'b101, 0, 32'h0000BEEF, 1'b0);
      txn("sb_11",   1'b1, 32'h11, 32'hAAAAAA55, 3'b000, 0, 32'h0,        1'b0);
      txn("lw_10b",  1'b0, 32'h10, 32'h0,        3'b010, 0, 32'hDEAD55EF, 1'b0);
      txn("lw_mis",  1'b0, 32'h12, 32'h0,        3'b010, 0, 32'h0,        1'b1);
      txn("sw_00",   1'b1, 32'h0,  32'h11223344, 3'b010, 0, 32'h0,        1'b0);
      txn("sw_oor",  1'b1, 32'h400, 32'hCAFEBABE, 3'b010, 0, 32'h0,       1'b1);
      txn("lw_00",   1'b0, 32'h0,  32'h0,        3'b010, 0, 32'h11223344, 1'b0);
      txn("lw_hold", 1'b0, 32'h10, 32'h0,        3'b010, 3, 32'hDEAD55EF, 1'b0);
      txn("ld_f3_3", 1'b0, 32'h10, 32'h0,        3'b011, 0, 32'h0,        1'b1);
      txn("st_f3_4", 1'b1, 32'h10, 32'h01020304, 3'b100, 0, 32'h0,        1'b1);
      txn("sh_mis",  1'b1, 32'h11, 32'h0000FFFF, 3'b001, 0, 32'h0,        1'b1);
      txn("lw_10c",  1'b0, 32'h10, 32'h0,        3'b010, 0, 32'hDEAD55EF, 1'b0);
      txn("sw_20",   1'b1, 32'h20, 32'hCAFEF00D, 3'b010, 0, 32'h0,        1'b0);

      // Store aborted by reset while it sits in the wait state.
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b1;
      bus.req_addr   = 32'h20;
      bus.req_wdata  = 32'h12345678;
      bus.req_funct3 = 3'b010;
      @(negedge clk);
      bus.req_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      chk("abort.rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("abort.req_ready", 32'(bus.req_ready), 32'd1);
      rst = 1'b1;
      $display("txn %-10s SW 12345678 @20 aborted by reset in WAIT", "abort");

      txn("lw_20",   1'b0, 32'h20, 32'h0,        3'b010, 0, 32'hCAFEF00D, 1'b0);
      txn("sh_22",   1'b1, 32'h22, 32'hFFFF1234, 3'b001, 0, 32'h0,        1'b0);
      txn("lw_20b",  1'b0, 32'h20, 32'h0,        3'b010, 0, 32'h1234F00D, 1'b0);
      txn("lh_22",   1'b0, 32'h22, 32'h0,        3'b001, 0, 32'h00001234, 1'b0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
